// File: rtl/activation_pkg.sv
// Shared definitions for the activation unit: mode encoding and its width.
package activation_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        ACT_BYPASS = 2'd0,
        ACT_RELU   = 2'd1,
        ACT_LEAKY  = 2'd2,
        ACT_CLIP   = 2'd3
    } act_mode_e;

endpackage

// File: rtl/act_lane.sv
// Per-element activation datapath, two register stages.
//   S1: negative handling (zero / leaky shift / pass).
//   S2: upper clip for ACT_CLIP and zero detect.
// Ports:
//   clk, rst_n        clock, async active-low reset (clears both stages)
//   s1_en_i, s2_en_i  stage load enables from the handshake control
//   x_i, mode_i       element and mode entering S1
//   s1_mode_i         mode of the beat held in S1 (used by S2)
//   s1_clip_i         clip bound of the beat held in S1
//   y_o, zero_o       S2 result and its equals-zero flag
module act_lane
    import activation_pkg::*;
#(
    parameter int W          = 16,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s1_en_i,
    input  logic                s2_en_i,
    input  logic signed [W-1:0] x_i,
    input  logic [MODE_W-1:0]   mode_i,
    input  logic [MODE_W-1:0]   s1_mode_i,
    input  logic [W-1:0]        s1_clip_i,
    output logic [W-1:0]        y_o,
    output logic                zero_o
);

    logic signed [W-1:0] s1_d, s1_q;
    logic [W-1:0]        s2_d, s2_q;
    logic                z_q;

    always_comb begin
        s1_d = x_i;
        case (mode_i)
            ACT_RELU,
            ACT_CLIP:  s1_d = x_i[W-1] ? '0 : x_i;
            ACT_LEAKY: s1_d = x_i[W-1] ? (x_i >>> LEAK_SHIFT) : x_i;
            default:   s1_d = x_i;
        endcase
    end

    // In clip mode S1 already forced the value non-negative, so a zero-extended
    // compare against the unsigned bound is exact; a bound above max positive
    // therefore never clips.
    always_comb begin
        s2_d = s1_q;
        if (s1_mode_i == ACT_CLIP && {1'b0, s1_q} > {1'b0, s1_clip_i})
            s2_d = s1_clip_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
            z_q  <= 1'b0;
        end else begin
            if (s1_en_i) s1_q <= s1_d;
            if (s2_en_i) begin
                s2_q <= s2_d;
                z_q  <= (s2_d == '0);
            end
        end
    end

    assign y_o    = s2_q;
    assign zero_o = z_q;

endmodule

// File: rtl/activation_unit.sv
// Vector activation unit: CHANNELS lanes behind a two-stage valid/ready
// pipeline, plus a saturating count of zero elements in delivered beats.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   in_valid/in_ready        input handshake
//   in_data, mode, clip_val  input beat (mode and clip travel with it)
//   out_valid/out_ready      output handshake
//   out_data, out_zero_mask  activated beat and per-element zero flags
//   clr_stats, zero_count    statistics clear and running zero count
module activation_unit
    import activation_pkg::*;
#(
    parameter int featureWidth = 16,
    parameter int CHANNELS     = 4,
    parameter int LEAK_SHIFT   = 3,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [CHANNELS*featureWidth-1:0] in_data,
    input  logic [MODE_W-1:0]                mode,
    input  logic [featureWidth-1:0]          clip_val,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [CHANNELS*featureWidth-1:0] out_data,
    output logic [CHANNELS-1:0]              out_zero_mask,
    input  logic                             clr_stats,
    output logic [CNT_WIDTH-1:0]             zero_count
);

    localparam int PW = $clog2(CHANNELS + 1);
    localparam int SW = CNT_WIDTH + 1;

    logic                    s1_v_q, s2_v_q;
    logic                    s1_en, s2_en, in_fire, out_fire;
    logic [MODE_W-1:0]       s1_mode_q;
    logic [featureWidth-1:0] s1_clip_q;

    // S2 can take a new beat when it is empty or its beat leaves this cycle;
    // S1 likewise when empty or when S2 takes its beat. No in_valid term.
    assign s2_en    = !s2_v_q || out_ready;
    assign in_ready = !s1_v_q || s2_en;
    assign in_fire  = in_valid && in_ready;
    assign s1_en    = in_fire;
    assign out_valid = s2_v_q;
    assign out_fire  = s2_v_q && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s2_v_q    <= 1'b0;
            s1_mode_q <= ACT_BYPASS;
            s1_clip_q <= '0;
        end else begin
            if (in_ready) s1_v_q <= in_valid;
            if (s2_en)    s2_v_q <= s1_v_q;
            if (in_fire) begin
                s1_mode_q <= mode;
                s1_clip_q <= clip_val;
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        act_lane #(
            .W         (featureWidth),
            .LEAK_SHIFT(LEAK_SHIFT)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .s1_en_i  (s1_en),
            .s2_en_i  (s2_en && s1_v_q),
            .x_i      (in_data[c*featureWidth +: featureWidth]),
            .mode_i   (mode),
            .s1_mode_i(s1_mode_q),
            .s1_clip_i(s1_clip_q),
            .y_o      (out_data[c*featureWidth +: featureWidth]),
            .zero_o   (out_zero_mask[c])
        );
    end

    // Zero statistics: saturating add of the mask popcount on each delivered
    // beat; a clear in the same cycle discards that beat's contribution.
    logic [PW-1:0]        pop;
    logic [SW-1:0]        sum;
    logic [CNT_WIDTH-1:0] cnt_d, cnt_q;

    always_comb begin
        pop = '0;
        for (int c = 0; c < CHANNELS; c++)
            pop = pop + PW'(out_zero_mask[c]);
        sum   = {1'b0, cnt_q} + SW'(pop);
        cnt_d = cnt_q;
        if (clr_stats)
            cnt_d = '0;
        else if (out_fire)
            cnt_d = sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign zero_count = cnt_q;

endmodule

// File: tb/tb_activation_unit.sv
module tb_activation_unit;
    localparam int FW = 16;
    localparam int CH = 4;
    localparam int CW = 5;   // small counter so saturation is reachable
    localparam int DW = FW * CH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [1:0]    mode = 2'd0;
    logic [FW-1:0] clip_val = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic [CH-1:0] out_zero_mask;
    logic          clr_stats = 1'b0;
    logic [CW-1:0] zero_count;

    int total = 0;
    int bad = 0;
    int mcnt = 0;   // expected zero_count

    always #5 clk = ~clk;

    activation_unit #(.featureWidth(FW), .CHANNELS(CH), .LEAK_SHIFT(3), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .mode(mode), .clip_val(clip_val),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_zero_mask(out_zero_mask), .clr_stats(clr_stats), .zero_count(zero_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void madd(input int n);
        mcnt = (mcnt + n > 31) ? 31 : mcnt + n;
    endfunction

    // One isolated beat with out_ready=1; optional clear on its output cycle.
    task automatic run_beat(input string tag, input logic [1:0] m, input logic [FW-1:0] cv,
                            input logic [DW-1:0] d, input logic [DW-1:0] exp_d,
                            input logic [CH-1:0] exp_m, input logic clr);
        @(negedge clk);
        in_valid = 1'b1; mode = m; clip_val = cv; in_data = d; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_vld"}, 64'(out_valid), 64'd1);
        chk({tag, "_dat"}, out_data, exp_d);
        chk({tag, "_msk"}, 64'(out_zero_mask), 64'(exp_m));
        clr_stats = clr;
        @(posedge clk); #1;
        clr_stats = 1'b0;
        if (clr) mcnt = 0; else madd($countones(exp_m));
        chk({tag, "_cnt"}, 64'(zero_count), 64'(mcnt));
        chk({tag, "_idle"}, 64'(out_valid), 64'd0);
    endtask

    logic [DW-1:0] bq [8];
    logic [CH-1:0] mq [8];

    initial begin
        #2;
        chk("rst_vld", 64'(out_valid), 64'd0);
        chk("rst_dat", out_data, 64'd0);
        chk("rst_msk", 64'(out_zero_mask), 64'd0);
        chk("rst_cnt", 64'(zero_count), 64'd0);
        chk("rst_rdy", 64'(in_ready), 64'd1);
        @(negedge clk); rst_n = 1'b1;

        // elements listed ch3..ch0
        run_beat("relu", 2'd1, 16'd0, {16'h8000, 16'h0007, 16'h0000, 16'hFFFB},
                 {16'h0000, 16'h0007, 16'h0000, 16'h0000}, 4'b1011, 1'b0);
        run_beat("leaky", 2'd2, 16'd0, {16'hFFF7, 16'h0008, 16'hFFFF, 16'hFFF0},
                 {16'hFFFE, 16'h0008, 16'hFFFF, 16'hFFFE}, 4'b0000, 1'b0);
        run_beat("clip", 2'd3, 16'd100, {16'h0063, 16'h0064, 16'hFFFD, 16'h00FA},
                 {16'h0063, 16'h0064, 16'h0000, 16'h0064}, 4'b0010, 1'b0);
        run_beat("clipmax", 2'd3, 16'hFFFF, {4{16'h7FFF}}, {4{16'h7FFF}}, 4'b0000, 1'b0);
        run_beat("clip0", 2'd3, 16'h0000, {16'h0005, 16'hFFFF, 16'h7FFF, 16'h0001},
                 64'd0, 4'b1111, 1'b0);   // count now 8

        // 8 back-to-back bypass beats, out_ready low on cycles 3..5
        for (int i = 0; i < 8; i++) begin
            bq[i] = {16'(-i), 16'(100 + i), 16'h0000, 16'(i)};
            mq[i] = (i == 0) ? 4'b1011 : 4'b0010;
        end
        begin
            int ii = 0, oi = 0;
            logic saw_full = 1'b0;
            for (int k = 0; k < 40 && oi < 8; k++) begin
                @(negedge clk);
                out_ready = !(k >= 3 && k <= 5);
                in_valid  = (ii < 8);
                mode      = 2'd0;
                in_data   = (ii < 8) ? bq[ii] : '0;
                #1;
                if (!in_ready) saw_full = 1'b1;
                if (in_valid && in_ready) ii++;
                if (out_valid && !out_ready && oi < 8)
                    chk("b2b_hold", out_data, bq[oi]);
                if (out_valid && out_ready) begin
                    chk("b2b_dat", out_data, bq[oi]);
                    chk("b2b_msk", 64'(out_zero_mask), 64'(mq[oi]));
                    madd($countones(mq[oi]));
                    oi++;
                end
            end
            in_valid = 1'b0; out_ready = 1'b1;
            chk("b2b_n", 64'(oi), 64'd8);
            chk("b2b_full", 64'(saw_full), 64'd1);
            @(posedge clk); #1;
            chk("b2b_cnt", 64'(zero_count), 64'(mcnt));   // 8 + 10 = 18
        end

        // mode switch exactly at beat boundary: ReLU then bypass on same data
        @(negedge clk);
        in_valid = 1'b1; mode = 2'd1; in_data = {4{16'hFFFF}};
        @(posedge clk); #1;
        mode = 2'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mb_a", out_data, 64'd0);
        @(posedge clk); #1;
        chk("mb_b", out_data, {4{16'hFFFF}});
        madd(4);
        @(posedge clk); #1;
        chk("mb_cnt", 64'(zero_count), 64'(mcnt));   // 22

        // clear coincident with a mask-1111 transfer
        run_beat("clr", 2'd1, 16'd0, {4{16'h8001}}, 64'd0, 4'b1111, 1'b1);

        // saturation: 9 all-zero beats = 36 zeros into a 5-bit counter
        @(negedge clk);
        in_valid = 1'b1; mode = 2'd1; in_data = {4{16'hFFFF}};
        repeat (9) @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("sat_cnt", 64'(zero_count), 64'd31);

        // reset with two beats in flight, output stalled
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; mode = 2'd0; in_data = {4{16'h1234}};
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("fl_vld", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("ar_vld", 64'(out_valid), 64'd0);
        chk("ar_dat", out_data, 64'd0);
        chk("ar_cnt", 64'(zero_count), 64'd0);
        chk("ar_rdy", 64'(in_ready), 64'd1);
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
        begin
            int seen = 0;
            repeat (6) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            chk("ar_drop", 64'(seen), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/activation_unit.md
ACTIVATION_UNIT -- requirements
Module: activation_unit

Interface
REQ-001 SHALL have parameter featureWidth, default 16, signed two's-complement element width (>=4).
REQ-002 SHALL have parameter CHANNELS, default 4, elements per vector beat (>=1).
REQ-003 SHALL have parameter LEAK_SHIFT, default 3, arithmetic right-shift applied to negative elements in leaky mode (0..featureWidth-1).
REQ-004 SHALL have parameter CNT_WIDTH, default 32, width of the zero-statistics counter.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 in_valid  input  1  input beat valid.
REQ-008 in_ready  output  1  unit accepts the input beat this cycle.
REQ-009 in_data  input  CHANNELS*featureWidth  packed signed elements, channel 0 in LSBs.
REQ-010 mode  input  2  activation mode, sampled with the beat: 0 bypass, 1 ReLU, 2 leaky ReLU, 3 clipped ReLU.
REQ-011 clip_val  input  featureWidth  unsigned upper bound for mode 3, sampled with the beat.
REQ-012 out_valid  output  1  output beat valid.
REQ-013 out_ready  input  1  downstream accepts the output beat.
REQ-014 out_data  output  CHANNELS*featureWidth  activated elements, same packing as in_data.
REQ-015 out_zero_mask  output  CHANNELS  bit c set when out_data element c equals 0.
REQ-016 clr_stats  input  1  synchronous clear of zero_count.
REQ-017 zero_count  output  CNT_WIDTH  running count of zero elements in accepted output beats.

Function
REQ-018 Transfers SHALL occur only on valid&ready at both ports; out_data, out_zero_mask SHALL hold stable while out_valid&!out_ready.
REQ-019 Pipeline SHALL have two register stages (S1: negative handling; S2: clip, zero mask); latency 2 cycles from input transfer to out_valid with no stall.
REQ-020 Each stage SHALL advance when empty or when the next stage advances; in_ready = !S1_valid | S2 advances; full throughput 1 beat/cycle when out_ready=1.
REQ-021 in_ready SHALL NOT depend combinationally on in_valid.
REQ-022 Mode 0: out element = x.
REQ-023 Mode 1: out = x if MSB 0, else 0.
REQ-024 Mode 2: out = x if MSB 0, else x >>> LEAK_SHIFT (sign-preserving; e.g. -1 -> -1, -16 -> -2 at shift 3).
REQ-025 Mode 3: out = min(max(x,0), clip_val), comparison in featureWidth+1 bits so clip_val above max positive never clips; clip_val 0 forces all 0.
REQ-026 Mode and clip_val SHALL travel with their beat; mode change between consecutive beats SHALL take effect exactly at the beat boundary.
REQ-027 zero_count SHALL increment by popcount(out_zero_mask) on each output transfer, saturating at 2^CNT_WIDTH-1.
REQ-028 clr_stats SHALL set zero_count to 0 next cycle; coincident output transfer count SHALL be discarded (clear wins).
REQ-029 Stalled beats SHALL be counted once, on the transfer cycle only.

Reset
REQ-030 rst_n low SHALL immediately clear S1/S2 valid, out_valid=0, out_data=0, out_zero_mask=0, zero_count=0.
REQ-031 Beats in flight at reset SHALL be dropped, never emitted.
REQ-032 in_ready SHALL be 1 during and after reset (pipeline empty).
REQ-033 Reset release SHALL be accepted asynchronously; first transfer permitted on the first rising edge with rst_n high.

Structure
REQ-034 Shared package activation_pkg SHALL hold the mode enumeration (ACT_BYPASS, ACT_RELU, ACT_LEAKY, ACT_CLIP) and mode width constant.
REQ-035 Per-element datapath SHALL be sub-module act_lane, instantiated CHANNELS times; handshake, valid pipeline and counter SHALL live in activation_unit.

Verification
REQ-036 Mode 1, CHANNELS=4, in_data {-5,0,7,-32768}, out_ready=1 -> 2 cycles later out {0,0,7,0}, mask 4'b1011, zero_count +3.
REQ-037 Mode 2, shift 3, {-16,-1,8,-9} -> {-2,-1,8,-2}, mask 0.
REQ-038 Mode 3, clip_val 100, {250,-3,100,99} -> {100,0,100,99}; clip_val 16'hFFFF, x=32767 -> 32767.
REQ-039 Back-to-back 8 beats, out_ready low cycles 3-5 -> no loss/duplication, order preserved, in_ready low once both stages full, zero_count counts each beat once.
REQ-040 rst_n asserted with two beats in flight -> out_valid drops immediately, no beat emitted after release, zero_count=0.
REQ-041 clr_stats coincident with transfer of mask 4'b1111 -> zero_count=0 next cycle; counter preset near max saturates at 2^CNT_WIDTH-1.
